// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: ROB geometry, retire-class opcodes and the ROB entry layout.
// Every file in this slice imports it.
package tomasulo_pkg;

   localparam int ROB_DEPTH = 8;
   localparam int IDX_W     = 3;
   localparam int XLEN      = 32;

   localparam logic [6:0] OP_ADD  = 7'b0110011;
   localparam logic [6:0] OP_MUL  = 7'b1100011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;

   typedef struct packed {
      logic            valid;
      logic            ready;
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [XLEN-1:0] value;
   } rob_entry_t;

   typedef enum logic [1:0] {
      RS_NONE = 2'd0,
      RS_ADD  = 2'd1,
      RS_MUL  = 2'd2,
      RS_LOAD = 2'd3
   } rs_class_t;

   function automatic rs_class_t rs_class_of(input logic [6:0] opcode);
      rs_class_t cls;
      cls = RS_NONE;
      case (opcode)
         OP_ADD:  cls = RS_ADD;
         OP_MUL:  cls = RS_MUL;
         OP_LOAD: cls = RS_LOAD;
         default: cls = RS_NONE;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/rob_commit_writer_table.sv
// Youngest-writer table: for each architectural register, the ROB index of its latest
// in-flight producer plus a valid bit.
module writer_table
   import tomasulo_pkg::*;
(
   input  logic             clk1,
   input  logic             rst,
   input  logic             set_en,
   input  logic [4:0]       set_rd,
   input  logic [IDX_W-1:0] set_idx,
   input  logic             clr_en,
   input  logic [4:0]       clr_rd,
   input  logic [IDX_W-1:0] clr_idx,
   output logic             clr_fire
);

   logic             yv_reg       [32];
   logic [IDX_W-1:0] youngest_reg [32];
   logic             set_live;

   assign set_live = set_en && (set_rd != 5'd0);

   // A clear only lands when the retiring entry is still the youngest writer, and a
   // same-cycle allocation of that register takes priority over it.
   assign clr_fire = clr_en && (clr_rd != 5'd0) && yv_reg[clr_rd] &&
                     (youngest_reg[clr_rd] == clr_idx) &&
                     !(set_live && (set_rd == clr_rd));

   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_reg
         always_ff @(posedge clk1 or posedge rst) begin
            if (rst) begin
               yv_reg[gi]       <= 1'b0;
               youngest_reg[gi] <= '0;
            end else if (set_live && (set_rd == 5'(gi))) begin
               yv_reg[gi]       <= 1'b1;
               youngest_reg[gi] <= set_idx;
            end else if (clr_fire && (clr_rd == 5'(gi))) begin
               yv_reg[gi]       <= 1'b0;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer with in-order single-entry retirement: dispatch allocates at tail, the CDB
// marks entries ready, head retires into the register file, tag clears and RS credits.
module rob_commit
   import tomasulo_pkg::*;
(
   input  logic             clk1,
   input  logic             rst,
   input  logic             alloc_valid,
   output logic             alloc_ready,
   input  logic [6:0]       alloc_opcode,
   input  logic [4:0]       alloc_rd,
   output logic [IDX_W-1:0] alloc_idx,
   input  logic             wb_valid,
   input  logic [IDX_W-1:0] wb_idx,
   input  logic [XLEN-1:0]  wb_value,
   output logic             commit_valid,
   output logic             commit_we,
   output logic [4:0]       commit_rd,
   output logic [XLEN-1:0]  commit_value,
   output logic [IDX_W-1:0] commit_idx,
   output logic             tag_clr_valid,
   output logic [4:0]       tag_clr_rd,
   output logic             rs_free_add,
   output logic             rs_free_mul,
   output logic             rs_free_load,
   output logic [IDX_W:0]   count
);

   localparam logic [IDX_W:0] DEPTH_C = ROB_DEPTH[IDX_W:0];

   rob_entry_t       rob_reg [ROB_DEPTH];
   rob_entry_t       head_entry;
   logic [IDX_W-1:0] head_reg, head_next;
   logic [IDX_W-1:0] tail_reg, tail_next;
   logic [IDX_W:0]   count_reg, count_next;
   logic             do_alloc;
   logic             do_retire;
   logic             clr_fire;
   rs_class_t        retire_class;

   logic             commit_valid_reg;
   logic             commit_we_reg;
   logic [4:0]       commit_rd_reg;
   logic [XLEN-1:0]  commit_value_reg;
   logic [IDX_W-1:0] commit_idx_reg;
   logic             tag_clr_valid_reg;
   logic [4:0]       tag_clr_rd_reg;
   logic             rs_free_add_reg;
   logic             rs_free_mul_reg;
   logic             rs_free_load_reg;

   // Full is decided from count alone; a retire in the same cycle does not reopen a slot.
   assign alloc_ready  = (count_reg < DEPTH_C);
   assign do_alloc     = alloc_valid && alloc_ready;
   assign head_entry   = rob_reg[head_reg];
   assign do_retire    = head_entry.valid && head_entry.ready;
   assign retire_class = rs_class_of(head_entry.opcode);

   generate
      for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk1 or posedge rst) begin
            if (rst) begin
               rob_reg[gi] <= '0;
            end else if (do_alloc && (tail_reg == IDX_W'(gi))) begin
               // Allocation owns the slot this cycle, so a colliding writeback is dropped.
               rob_reg[gi].valid  <= 1'b1;
               rob_reg[gi].ready  <= 1'b0;
               rob_reg[gi].opcode <= alloc_opcode;
               rob_reg[gi].rd     <= alloc_rd;
               rob_reg[gi].value  <= '0;
            end else begin
               if (wb_valid && (wb_idx == IDX_W'(gi)) && rob_reg[gi].valid) begin
                  rob_reg[gi].value <= wb_value;
                  rob_reg[gi].ready <= 1'b1;
               end
               if (do_retire && (head_reg == IDX_W'(gi))) begin
                  rob_reg[gi].valid <= 1'b0;
                  rob_reg[gi].ready <= 1'b0;
               end
            end
         end
      end
   endgenerate

   writer_table u_writer_table (
      .clk1     (clk1),
      .rst      (rst),
      .set_en   (do_alloc),
      .set_rd   (alloc_rd),
      .set_idx  (tail_reg),
      .clr_en   (do_retire),
      .clr_rd   (head_entry.rd),
      .clr_idx  (head_reg),
      .clr_fire (clr_fire)
   );

   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (do_alloc) begin
         tail_next = tail_reg + 1'b1;
      end
      if (do_retire) begin
         head_next = head_reg + 1'b1;
      end
      case ({do_alloc, do_retire})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   // Pulses are re-evaluated every cycle; retired payload fields hold until the next retire.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         commit_valid_reg  <= 1'b0;
         commit_we_reg     <= 1'b0;
         commit_rd_reg     <= '0;
         commit_value_reg  <= '0;
         commit_idx_reg    <= '0;
         tag_clr_valid_reg <= 1'b0;
         tag_clr_rd_reg    <= '0;
         rs_free_add_reg   <= 1'b0;
         rs_free_mul_reg   <= 1'b0;
         rs_free_load_reg  <= 1'b0;
      end else begin
         commit_valid_reg  <= do_retire;
         commit_we_reg     <= do_retire && (head_entry.rd != 5'd0);
         tag_clr_valid_reg <= clr_fire;
         tag_clr_rd_reg    <= clr_fire ? head_entry.rd : 5'd0;
         rs_free_add_reg   <= do_retire && (retire_class == RS_ADD);
         rs_free_mul_reg   <= do_retire && (retire_class == RS_MUL);
         rs_free_load_reg  <= do_retire && (retire_class == RS_LOAD);
         if (do_retire) begin
            commit_rd_reg    <= head_entry.rd;
            commit_value_reg <= head_entry.value;
            commit_idx_reg   <= head_reg;
         end
      end
   end

   assign alloc_idx     = tail_reg;
   assign count         = count_reg;
   assign commit_valid  = commit_valid_reg;
   assign commit_we     = commit_we_reg;
   assign commit_rd     = commit_rd_reg;
   assign commit_value  = commit_value_reg;
   assign commit_idx    = commit_idx_reg;
   assign tag_clr_valid = tag_clr_valid_reg;
   assign tag_clr_rd    = tag_clr_rd_reg;
   assign rs_free_add   = rs_free_add_reg;
   assign rs_free_mul   = rs_free_mul_reg;
   assign rs_free_load  = rs_free_load_reg;

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus random traffic, checked against a
// queue-based model of in-flight instructions.
module tb_rob_commit;
   import tomasulo_pkg::*;

   logic             clk1 = 1'b0;
   logic             rst = 1'b0;
   logic             alloc_valid = 1'b0;
   logic             alloc_ready;
   logic [6:0]       alloc_opcode = '0;
   logic [4:0]       alloc_rd = '0;
   logic [IDX_W-1:0] alloc_idx;
   logic             wb_valid = 1'b0;
   logic [IDX_W-1:0] wb_idx = '0;
   logic [XLEN-1:0]  wb_value = '0;
   logic             commit_valid, commit_we, tag_clr_valid;
   logic [4:0]       commit_rd, tag_clr_rd;
   logic [XLEN-1:0]  commit_value;
   logic [IDX_W-1:0] commit_idx;
   logic             rs_free_add, rs_free_mul, rs_free_load;
   logic [IDX_W:0]   count;

   rob_commit dut (
      .clk1(clk1), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_opcode(alloc_opcode),
      .alloc_rd(alloc_rd), .alloc_idx(alloc_idx),
      .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value),
      .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
      .commit_value(commit_value), .commit_idx(commit_idx),
      .tag_clr_valid(tag_clr_valid), .tag_clr_rd(tag_clr_rd),
      .rs_free_add(rs_free_add), .rs_free_mul(rs_free_mul), .rs_free_load(rs_free_load),
      .count(count)
   );

   always #5 clk1 = ~clk1;

   typedef struct {
      int          idx;
      logic [4:0]  rd;
      logic [6:0]  op;
      bit          rdy;
      logic [31:0] val;
   } m_entry_t;

   m_entry_t q[$];
   int       m_tail = 0;
   int       n_checks = 0;
   int       n_fail = 0;
   int       load_pulses = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, predict from the in-flight list, advance, compare.
   task automatic step(input bit av, input logic [6:0] op, input logic [4:0] rd,
                       input bit wv, input logic [2:0] wi, input logic [31:0] wval);
      bit       acc, ret, clr;
      m_entry_t e, n;
      alloc_valid  = av;
      alloc_opcode = op;
      alloc_rd     = rd;
      wb_valid     = wv;
      wb_idx       = wi;
      wb_value     = wval;
      check_eq("alloc_ready", alloc_ready, q.size() < 8);
      check_eq("alloc_idx", alloc_idx, m_tail);
      check_eq("count", count, q.size());
      acc = av && (q.size() < 8);
      ret = (q.size() > 0) && q[0].rdy;
      clr = 1'b0;
      e = '{idx: 0, rd: '0, op: '0, rdy: 1'b0, val: '0};
      if (ret) e = q[0];
      if (wv) begin
         for (int i = 0; i < q.size(); i++) begin
            if (q[i].idx == int'(wi)) begin
               q[i].rdy = 1'b1;
               q[i].val = wval;
            end
         end
      end
      if (ret) begin
         void'(q.pop_front());
         // Tag clears only if no younger in-flight (or same-cycle) writer of rd exists.
         clr = (e.rd != 5'd0) && !(acc && rd == e.rd);
         for (int i = 0; i < q.size(); i++) if (q[i].rd == e.rd) clr = 1'b0;
      end
      if (acc) begin
         n = '{idx: m_tail, rd: rd, op: op, rdy: 1'b0, val: '0};
         q.push_back(n);
         m_tail = (m_tail + 1) % 8;
      end
      @(posedge clk1);
      #1;
      alloc_valid = 1'b0;
      wb_valid    = 1'b0;
      if (rs_free_load) load_pulses++;
      check_eq("commit_valid", commit_valid, ret);
      check_eq("tag_clr_valid", tag_clr_valid, clr);
      check_eq("rs_free_add", rs_free_add, ret && e.op == OP_ADD);
      check_eq("rs_free_mul", rs_free_mul, ret && e.op == OP_MUL);
      check_eq("rs_free_load", rs_free_load, ret && e.op == OP_LOAD);
      check_eq("commit_we", commit_we, ret && e.rd != 5'd0);
      if (ret) begin
         check_eq("commit_rd", commit_rd, e.rd);
         check_eq("commit_value", commit_value, e.val);
         check_eq("commit_idx", commit_idx, e.idx);
      end
      if (clr) check_eq("tag_clr_rd", tag_clr_rd, e.rd);
   endtask

   task automatic idle();
      step(1'b0, 7'd0, 5'd0, 1'b0, 3'd0, 32'd0);
   endtask

   task automatic do_reset();
      alloc_valid = 1'b0;
      wb_valid    = 1'b0;
      rst = 1'b1;
      @(posedge clk1);
      #1;
      rst = 1'b0;
      q.delete();
      m_tail = 0;
   endtask

   task automatic drain();
      int  widx;
      for (int k = 0; k < 64 && q.size() > 0; k++) begin
         widx = -1;
         for (int i = q.size() - 1; i >= 0; i--) if (!q[i].rdy) widx = q[i].idx;
         if (widx >= 0) step(1'b0, 7'd0, 5'd0, 1'b1, 3'(widx), $urandom);
         else idle();
      end
      idle();
      check_eq("drain_count", count, 0);
   endtask

   function automatic logic [6:0] rand_op();
      case ($urandom_range(0, 3))
         0:       return OP_ADD;
         1:       return OP_MUL;
         2:       return OP_LOAD;
         default: return 7'($urandom);
      endcase
   endfunction

   initial begin
      #2 rst = 1'b1;
      @(posedge clk1);
      #1;
      check_eq("rst_alloc_ready", alloc_ready, 1);
      check_eq("rst_count", count, 0);
      check_eq("rst_alloc_idx", alloc_idx, 0);
      check_eq("rst_commit_valid", commit_valid, 0);
      check_eq("rst_commit_we", commit_we, 0);
      check_eq("rst_commit_rd", commit_rd, 0);
      check_eq("rst_commit_value", commit_value, 0);
      check_eq("rst_commit_idx", commit_idx, 0);
      check_eq("rst_tag_clr", {tag_clr_valid, tag_clr_rd}, 0);
      check_eq("rst_rs_free", {rs_free_add, rs_free_mul, rs_free_load}, 0);
      rst = 1'b0;

      // Single ADD: alloc, writeback, retire.
      step(1'b1, OP_ADD, 5'd5, 1'b0, 3'd0, 32'd0);
      step(1'b0, 7'd0, 5'd0, 1'b1, 3'd0, 32'h1234);
      idle();
      check_eq("t1_value", commit_value, 32'h1234);
      check_eq("t1_tag_clr_rd", tag_clr_rd, 5);
      idle();

      // Fill to full, one refused alloc, then drain.
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, OP_MUL, 5'(i + 8), 1'b0, 3'd0, 32'd0);
      step(1'b1, OP_ADD, 5'd3, 1'b0, 3'd0, 32'd0);
      check_eq("full_ready", alloc_ready, 0);
      check_eq("full_tail", alloc_idx, 0);
      drain();

      // Out-of-order writeback, in-order retire.
      do_reset();
      step(1'b1, OP_ADD, 5'd1, 1'b0, 3'd0, 32'd0);
      step(1'b1, OP_ADD, 5'd2, 1'b0, 3'd0, 32'd0);
      step(1'b0, 7'd0, 5'd0, 1'b1, 3'd1, 32'hBBBB);
      idle();
      step(1'b0, 7'd0, 5'd0, 1'b1, 3'd0, 32'hAAAA);
      for (int i = 0; i < 3; i++) idle();

      // Two writers of r7: only the younger clears the tag.
      do_reset();
      step(1'b1, OP_MUL, 5'd7, 1'b0, 3'd0, 32'd0);
      step(1'b1, OP_ADD, 5'd7, 1'b1, 3'd0, 32'h70);
      step(1'b0, 7'd0, 5'd0, 1'b1, 3'd1, 32'h71);
      for (int i = 0; i < 3; i++) idle();

      // Wrap: 20 LOAD r0 triples.
      do_reset();
      load_pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, OP_LOAD, 5'd0, 1'b0, 3'd0, 32'd0);
         step(1'b0, 7'd0, 5'd0, 1'b1, 3'(m_tail + 7), $urandom);
         idle();
      end
      check_eq("wrap_load_pulses", load_pulses, 20);
      check_eq("wrap_tail", alloc_idx, 4);

      // Random traffic.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         bit         av, wv;
         logic [2:0] wi;
         av = $urandom_range(0, 99) < 55;
         wv = $urandom_range(0, 99) < 60;
         wi = 3'($urandom);
         if (q.size() > 0 && $urandom_range(0, 9) < 8) wi = 3'(q[$urandom_range(0, q.size() - 1)].idx);
         step(av, rand_op(), 5'($urandom_range(0, 7)), wv, wi, $urandom);
      end
      drain();

      // Reset with three pending entries and a writeback in flight.
      step(1'b1, OP_ADD, 5'd3, 1'b0, 3'd0, 32'd0);
      step(1'b1, OP_MUL, 5'd4, 1'b0, 3'd0, 32'd0);
      step(1'b1, OP_LOAD, 5'd5, 1'b0, 3'd0, 32'd0);
      wb_valid = 1'b1;
      wb_idx   = q[0].idx[2:0];
      wb_value = 32'hDEAD;
      #2 rst = 1'b1;
      #1;
      check_eq("mid_rst_count", count, 0);
      check_eq("mid_rst_ready", alloc_ready, 1);
      @(posedge clk1);
      #1;
      rst = 1'b0;
      q.delete();
      m_tail = 0;
      step(1'b0, 7'd0, 5'd0, 1'b1, 3'd0, 32'hBEEF);
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
